// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing constants for the VGA pipeline. The tile lookup
// and game logic import the same values, so there is one source of truth.
package vga_timing_gen_pkg;

    // Horizontal timing in pixels
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Derived sync windows: low for START <= count < END
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Coordinate width shared by x and y
    localparam int COORD_W = 10;

    // Sync/DE bundle carried through the delay line
    typedef struct packed {
        logic de;
        logic hs_n;
        logic vs_n;
    } sync_t;

    // Inactive level of the bundle: no data, both syncs deasserted (high)
    localparam sync_t SYNC_IDLE = '{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the draw stages.
// Handshake: there is no valid/ready; the stream never stalls and every
// consumer samples all signals on every pixel clock, qualifying pixel
// data with oDE.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    logic [COORD_W-1:0] ovga_x;
    logic [COORD_W-1:0] ovga_y;
    logic               oDE;
    logic               oHSync;
    logic               oVSync;
    logic               oFrame_start;
    logic               oVBlank_start;

    modport master (
        output ovga_x, ovga_y, oDE, oHSync, oVSync, oFrame_start, oVBlank_start
    );

    modport slave (
        input  ovga_x, ovga_y, oDE, oHSync, oVSync, oFrame_start, oVBlank_start
    );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register that aligns sync/DE with the registered RGB
// of the draw stage. Every stage resets to RESET_VAL so no partial sync
// pulse survives a reset. DEPTH = 0 is a plain wire.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Clock and reset have no load in the zero-depth build
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_q      = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift one stage per pixel clock; reset clears every stage
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running x/y counters, sync/DE decode
// delayed to match the draw pipeline, and undelayed frame strobes.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int DELAY      = 2,
    parameter int G_H_ACTIVE = H_ACTIVE,
    parameter int G_H_FP     = H_FP,
    parameter int G_H_SYNC   = H_SYNC,
    parameter int G_H_BP     = H_BP,
    parameter int G_V_ACTIVE = V_ACTIVE,
    parameter int G_V_FP     = V_FP,
    parameter int G_V_SYNC   = V_SYNC,
    parameter int G_V_BP     = V_BP
) (
    input  logic             iVGA_CLK,
    input  logic             iReset,
    vga_timing_gen_if.master vga
);

    localparam int G_H_TOTAL = G_H_ACTIVE + G_H_FP + G_H_SYNC + G_H_BP;
    localparam int G_V_TOTAL = G_V_ACTIVE + G_V_FP + G_V_SYNC + G_V_BP;

    localparam logic [COORD_W-1:0] L_H_LAST   = COORD_W'(G_H_TOTAL - 1);
    localparam logic [COORD_W-1:0] L_V_LAST   = COORD_W'(G_V_TOTAL - 1);
    localparam logic [COORD_W-1:0] L_H_ACTIVE = COORD_W'(G_H_ACTIVE);
    localparam logic [COORD_W-1:0] L_V_ACTIVE = COORD_W'(G_V_ACTIVE);
    localparam logic [COORD_W-1:0] L_HS_START = COORD_W'(G_H_ACTIVE + G_H_FP);
    localparam logic [COORD_W-1:0] L_HS_END   = COORD_W'(G_H_ACTIVE + G_H_FP + G_H_SYNC);
    localparam logic [COORD_W-1:0] L_VS_START = COORD_W'(G_V_ACTIVE + G_V_FP);
    localparam logic [COORD_W-1:0] L_VS_END   = COORD_W'(G_V_ACTIVE + G_V_FP + G_V_SYNC);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] w_x_next;
    logic [COORD_W-1:0] w_y_next;
    logic               r_frame_start;
    logic               r_vblank_start;
    sync_t              w_sync;
    sync_t              w_sync_dly;

    // Next counter values: x wraps at end of line and carries into y;
    // both wrap together at the last pixel of the frame
    always_comb begin
        w_x_next = r_x + 1'b1;
        w_y_next = r_y;
        if (r_x == L_H_LAST) begin
            w_x_next = '0;
            if (r_y == L_V_LAST) begin
                w_y_next = '0;
            end else begin
                w_y_next = r_y + 1'b1;
            end
        end
    end

    // Counter registers; strobes come from the next-state values so they
    // are high in exactly the cycle the counters show the target position
    always_ff @(posedge iVGA_CLK) begin
        if (iReset) begin
            r_x            <= '0;
            r_y            <= '0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
        end else begin
            r_x            <= w_x_next;
            r_y            <= w_y_next;
            r_frame_start  <= (w_x_next == '0) && (w_y_next == '0);
            r_vblank_start <= (w_x_next == '0) && (w_y_next == L_V_ACTIVE);
        end
    end

    // Undelayed decode from the counter registers; vsync depends on y only
    // so its edges line up with x = 0
    always_comb begin
        w_sync      = SYNC_IDLE;
        w_sync.de   = (r_x < L_H_ACTIVE) && (r_y < L_V_ACTIVE);
        w_sync.hs_n = !((r_x >= L_HS_START) && (r_x < L_HS_END));
        w_sync.vs_n = !((r_y >= L_VS_START) && (r_y < L_VS_END));
    end

    sync_delay_line #(
        .WIDTH     ($bits(sync_t)),
        .DEPTH     (DELAY),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .i_clk (iVGA_CLK),
        .i_rst (iReset),
        .i_d   (w_sync),
        .o_q   (w_sync_dly)
    );

    assign vga.ovga_x        = r_x;
    assign vga.ovga_y        = r_y;
    assign vga.oDE           = w_sync_dly.de;
    assign vga.oHSync        = w_sync_dly.hs_n;
    assign vga.oVSync        = w_sync_dly.vs_n;
    assign vga.oFrame_start  = r_frame_start;
    assign vga.oVBlank_start = r_vblank_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full 640x480 instance for line-level
// timing, plus shrunk-raster instances (25x12, 300-cycle frames) at
// DELAY 0/2/4 for frame-level behaviour and a mid-frame reset.
module tb_vga_timing_gen;

  // Shrunk raster: H 16/2/4/3 = 25, V 8/1/2/1 = 12
  localparam int SH_A = 16, SH_FP = 2, SH_S = 4, SH_BP = 3;
  localparam int SV_A = 8,  SV_FP = 1, SV_S = 2, SV_BP = 1;
  localparam int NCYC  = 1700;
  // Sample where x = 21, y = 9 in the shrunk raster: delayed hs and vs both low
  localparam int MID_N = 9 * 25 + 21;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  int n_vec = 0;
  int n_err = 0;

  int n_a;
  int n_b;
  bit mid_done;

  // Statistics gathered during the run
  int full_hs_low_l0, full_hs_low_l1, full_de_l0, full_hs_fall;
  int s0_hs_fall, s4_hs_fall, s0_de_frame, s4_de_frame;
  int s2_de_frame, s2_vs_low_frame, s2_hs_low_frame;
  int s2_fs_cnt, s2_vb_cnt, s2_fs_first;
  logic full_hs_prev, s0_hs_prev, s4_hs_prev;

  vga_timing_gen_if if_full ();
  vga_timing_gen_if if_s0 ();
  vga_timing_gen_if if_s2 ();
  vga_timing_gen_if if_s4 ();

  vga_timing_gen #(.DELAY(2)) u_full (
    .iVGA_CLK (clk),
    .iReset   (rst_a),
    .vga      (if_full.master)
  );

  vga_timing_gen #(
    .DELAY(0), .G_H_ACTIVE(SH_A), .G_H_FP(SH_FP), .G_H_SYNC(SH_S), .G_H_BP(SH_BP),
    .G_V_ACTIVE(SV_A), .G_V_FP(SV_FP), .G_V_SYNC(SV_S), .G_V_BP(SV_BP)
  ) u_s0 (
    .iVGA_CLK (clk),
    .iReset   (rst_a),
    .vga      (if_s0.master)
  );

  vga_timing_gen #(
    .DELAY(2), .G_H_ACTIVE(SH_A), .G_H_FP(SH_FP), .G_H_SYNC(SH_S), .G_H_BP(SH_BP),
    .G_V_ACTIVE(SV_A), .G_V_FP(SV_FP), .G_V_SYNC(SV_S), .G_V_BP(SV_BP)
  ) u_s2 (
    .iVGA_CLK (clk),
    .iReset   (rst_b),
    .vga      (if_s2.master)
  );

  vga_timing_gen #(
    .DELAY(4), .G_H_ACTIVE(SH_A), .G_H_FP(SH_FP), .G_H_SYNC(SH_S), .G_H_BP(SH_BP),
    .G_V_ACTIVE(SV_A), .G_V_FP(SV_FP), .G_V_SYNC(SV_S), .G_V_BP(SV_BP)
  ) u_s4 (
    .iVGA_CLK (clk),
    .iReset   (rst_a),
    .vga      (if_s4.master)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference raster: n = clock edges since reset release. Counters are the
  // position n; sync/DE show the decode of position n - dly, or the idle
  // level while the delay line has not yet filled.
  task automatic check_dut(input string name, input int n, input int dly,
                           input int ha, input int hfp, input int hsy, input int hbp,
                           input int va, input int vfp, input int vsy, input int vbp,
                           input logic [9:0] x, input logic [9:0] y,
                           input logic de, input logic hs, input logic vs,
                           input logic fs, input logic vb);
    int ht, vt, ex, ey, m, mx, my;
    logic ede, ehs, evs, efs, evb;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    ex = n % ht;
    ey = (n / ht) % vt;
    if (n >= dly) begin
      m   = n - dly;
      mx  = m % ht;
      my  = (m / ht) % vt;
      ede = (mx < ha) && (my < va);
      ehs = !((mx >= ha + hfp) && (mx < ha + hfp + hsy));
      evs = !((my >= va + vfp) && (my < va + vfp + vsy));
    end else begin
      ede = 1'b0;
      ehs = 1'b1;
      evs = 1'b1;
    end
    efs = (n > 0) && (ex == 0) && (ey == 0);
    evb = (n > 0) && (ex == 0) && (ey == va);
    check_val({name, ".x"},  32'(x),  32'(ex));
    check_val({name, ".y"},  32'(y),  32'(ey));
    check_val({name, ".de"}, 32'(de), 32'(ede));
    check_val({name, ".hs"}, 32'(hs), 32'(ehs));
    check_val({name, ".vs"}, 32'(vs), 32'(evs));
    check_val({name, ".fs"}, 32'(fs), 32'(efs));
    check_val({name, ".vb"}, 32'(vb), 32'(evb));
  endtask

  task automatic check_all(input string sfx);
    check_dut({"full", sfx}, n_a, 2, 640, 16, 96, 48, 480, 10, 2, 33,
              if_full.ovga_x, if_full.ovga_y, if_full.oDE, if_full.oHSync,
              if_full.oVSync, if_full.oFrame_start, if_full.oVBlank_start);
    check_dut({"s0", sfx}, n_a, 0, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP,
              if_s0.ovga_x, if_s0.ovga_y, if_s0.oDE, if_s0.oHSync,
              if_s0.oVSync, if_s0.oFrame_start, if_s0.oVBlank_start);
    check_dut({"s4", sfx}, n_a, 4, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP,
              if_s4.ovga_x, if_s4.ovga_y, if_s4.oDE, if_s4.oHSync,
              if_s4.oVSync, if_s4.oFrame_start, if_s4.oVBlank_start);
    check_dut({"s2", sfx}, n_b, 2, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP,
              if_s2.ovga_x, if_s2.ovga_y, if_s2.oDE, if_s2.oHSync,
              if_s2.oVSync, if_s2.oFrame_start, if_s2.oVBlank_start);
  endtask

  // Accumulate run lengths, window counts and first-edge positions
  task automatic collect_stats();
    if (n_a < 800 && !if_full.oHSync) full_hs_low_l0++;
    if (n_a >= 800 && n_a < 1600 && !if_full.oHSync) full_hs_low_l1++;
    if (n_a >= 2 && n_a < 802 && if_full.oDE) full_de_l0++;
    if (full_hs_fall < 0 && full_hs_prev && !if_full.oHSync) full_hs_fall = n_a;
    if (s0_hs_fall < 0 && s0_hs_prev && !if_s0.oHSync) s0_hs_fall = n_a;
    if (s4_hs_fall < 0 && s4_hs_prev && !if_s4.oHSync) s4_hs_fall = n_a;
    if (n_a < 300 && if_s0.oDE) s0_de_frame++;
    if (n_a >= 4 && n_a < 304 && if_s4.oDE) s4_de_frame++;
    full_hs_prev = if_full.oHSync;
    s0_hs_prev   = if_s0.oHSync;
    s4_hs_prev   = if_s4.oHSync;
    if (mid_done && !rst_b) begin
      if (n_b >= 2 && n_b < 302) begin
        if (if_s2.oDE) s2_de_frame++;
        if (!if_s2.oVSync) s2_vs_low_frame++;
        if (!if_s2.oHSync) s2_hs_low_frame++;
      end
      if (n_b < 300 && if_s2.oFrame_start) s2_fs_first++;
      if (n_b <= 600 && if_s2.oFrame_start) s2_fs_cnt++;
      if (n_b <= 600 && if_s2.oVBlank_start) s2_vb_cnt++;
    end
  endtask

  initial begin
    full_hs_low_l0 = 0; full_hs_low_l1 = 0; full_de_l0 = 0;
    full_hs_fall = -1; s0_hs_fall = -1; s4_hs_fall = -1;
    s0_de_frame = 0; s4_de_frame = 0;
    s2_de_frame = 0; s2_vs_low_frame = 0; s2_hs_low_frame = 0;
    s2_fs_cnt = 0; s2_vb_cnt = 0; s2_fs_first = 0;
    full_hs_prev = 1'b1; s0_hs_prev = 1'b1; s4_hs_prev = 1'b1;
    mid_done = 1'b0;

    // Reset block
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_a = 0;
    n_b = 0;
    check_all("@rst");
    check_val("rst.full.hs", 32'(if_full.oHSync), 32'd1);
    check_val("rst.full.vs", 32'(if_full.oVSync), 32'd1);
    check_val("rst.full.de", 32'(if_full.oDE), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      check_all("");
      collect_stats();
      if (!mid_done && n_b == MID_N) begin
        check_val("mid.pre.hs_low", 32'(if_s2.oHSync), 32'd0);
        check_val("mid.pre.vs_low", 32'(if_s2.oVSync), 32'd0);
        rst_b    = 1'b1;
        mid_done = 1'b1;
      end else if (rst_b) begin
        check_val("mid.x",  32'(if_s2.ovga_x), 32'd0);
        check_val("mid.y",  32'(if_s2.ovga_y), 32'd0);
        check_val("mid.hs", 32'(if_s2.oHSync), 32'd1);
        check_val("mid.vs", 32'(if_s2.oVSync), 32'd1);
        check_val("mid.de", 32'(if_s2.oDE), 32'd0);
        check_val("mid.fs", 32'(if_s2.oFrame_start), 32'd0);
        check_val("mid.vb", 32'(if_s2.oVBlank_start), 32'd0);
        rst_b = 1'b0;
      end
      @(posedge clk);
      n_a++;
      n_b = rst_b ? 0 : n_b + 1;
      @(negedge clk);
    end

    // Aggregate timing checks
    check_val("full.hs_width_l0", 32'(full_hs_low_l0), 32'd96);
    check_val("full.hs_width_l1", 32'(full_hs_low_l1), 32'd96);
    check_val("full.hs_fall_n",   32'(full_hs_fall),   32'd658);
    check_val("full.de_line",     32'(full_de_l0),     32'd640);
    check_val("s0.hs_fall_n",     32'(s0_hs_fall),     32'd18);
    check_val("s4.hs_fall_n",     32'(s4_hs_fall),     32'd22);
    check_val("s0.de_frame",      32'(s0_de_frame),    32'd128);
    check_val("s4.de_frame",      32'(s4_de_frame),    32'd128);
    check_val("s2.de_frame",      32'(s2_de_frame),    32'd128);
    check_val("s2.vs_low_frame",  32'(s2_vs_low_frame), 32'd50);
    check_val("s2.hs_low_frame",  32'(s2_hs_low_frame), 32'd48);
    check_val("s2.fs_first",      32'(s2_fs_first),    32'd0);
    check_val("s2.fs_count",      32'(s2_fs_cnt),      32'd2);
    check_val("s2.vb_count",      32'(s2_vb_cnt),      32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
